// File: rtl/flight_mode.sv
// flight_mode: mode-select state machine feeding rec_data_buffer.
//
// Decodes and debounces the two aux switches (swa = arm/enable, swb = auto/assist),
// enforces a throttle/disarm interlock before arming, and sequences
// IDLE -> TAKEOFF -> HOVER, MANUAL pass-through, and AUTO_LAND -> IDLE on us timers.
//
// Ports:
//   us_clk           in   1 MHz clock
//   reset            in   asynchronous, active-high reset
//   swa_val          in   receiver switch A value (unsigned)
//   swb_val          in   receiver switch B value (unsigned)
//   throttle_rec_val in   receiver throttle (unsigned)
//   curr_motor_rate  in   motor_mixer output rate
//   rec_data_sel     out  registered selector code for rec_data_buffer
//   mode_change      out  one-cycle pulse in the first cycle a new code is visible
//   DEBUG_WIRE       out  {interlock_ok, swb_db, swa_db, state}, zero-extended

`ifndef PWM_VALUE_BIT_WIDTH
`define PWM_VALUE_BIT_WIDTH 8
`endif
`ifndef REC_DATA_SEL_BIT_WIDTH
`define REC_DATA_SEL_BIT_WIDTH 3
`endif
`ifndef DEBUG_WIRE_BIT_WIDTH
`define DEBUG_WIRE_BIT_WIDTH 8
`endif

module flight_mode #(
    parameter int unsigned DEBOUNCE_US      = 20000,
    parameter int unsigned TAKEOFF_US       = 2000000,
    parameter int unsigned LAND_TIMEOUT_US  = 8000000,
    parameter int unsigned SWITCH_THRESHOLD = 128,
    parameter int unsigned ARM_THROTTLE_MAX = 20,
    parameter int unsigned MOTOR_MIN        = 10
) (
    input  logic                               us_clk,
    input  logic                               reset,
    input  logic [`PWM_VALUE_BIT_WIDTH-1:0]    swa_val,
    input  logic [`PWM_VALUE_BIT_WIDTH-1:0]    swb_val,
    input  logic [`PWM_VALUE_BIT_WIDTH-1:0]    throttle_rec_val,
    input  logic [`PWM_VALUE_BIT_WIDTH-1:0]    curr_motor_rate,
    output logic [`REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel,
    output logic                               mode_change,
    output logic [`DEBUG_WIRE_BIT_WIDTH-1:0]   DEBUG_WIRE
);

    localparam int unsigned PW  = `PWM_VALUE_BIT_WIDTH;
    localparam int unsigned SW  = `REC_DATA_SEL_BIT_WIDTH;
    localparam int unsigned DW  = `DEBUG_WIRE_BIT_WIDTH;
    localparam int unsigned DBW = $clog2(DEBOUNCE_US + 1);

    localparam logic [PW-1:0]  SW_ON        = PW'(SWITCH_THRESHOLD);
    localparam logic [PW-1:0]  THR_MAX      = PW'(ARM_THROTTLE_MAX);
    localparam logic [PW-1:0]  MOT_MIN      = PW'(MOTOR_MIN);
    localparam logic [DBW-1:0] DB_LAST      = DBW'(DEBOUNCE_US - 1);
    localparam logic [23:0]    TAKEOFF_LAST = 24'(TAKEOFF_US - 1);
    localparam logic [23:0]    LAND_LAST    = 24'(LAND_TIMEOUT_US - 1);

    localparam logic [SW-1:0] REC_SEL_OFF           = SW'(0);
    localparam logic [SW-1:0] REC_SEL_AUTO_TAKE_OFF = SW'(1);
    localparam logic [SW-1:0] REC_SEL_HOVER         = SW'(2);
    localparam logic [SW-1:0] REC_SEL_PASS_THROUGH  = SW'(3);
    localparam logic [SW-1:0] REC_SEL_AUTO_LAND     = SW'(4);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTakeoff = 3'd1,
        StHover   = 3'd2,
        StManual  = 3'd3,
        StLand    = 3'd4
    } state_e;

    // ---------------- switch debouncers ----------------
    logic           swa_raw, swb_raw;
    logic           swa_db_q, swb_db_q;
    logic [DBW-1:0] swa_cnt_q, swb_cnt_q;

    assign swa_raw = (swa_val >= SW_ON);
    assign swb_raw = (swb_val >= SW_ON);

    // swa_db starts high so the pilot must visibly switch swa off before arming.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            swa_db_q  <= 1'b1;
            swa_cnt_q <= '0;
        end else if (swa_raw == swa_db_q) begin
            swa_cnt_q <= '0;
        end else if (swa_cnt_q == DB_LAST) begin
            swa_db_q  <= swa_raw;
            swa_cnt_q <= '0;
        end else begin
            swa_cnt_q <= swa_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            swb_db_q  <= 1'b0;
            swb_cnt_q <= '0;
        end else if (swb_raw == swb_db_q) begin
            swb_cnt_q <= '0;
        end else if (swb_cnt_q == DB_LAST) begin
            swb_db_q  <= swb_raw;
            swb_cnt_q <= '0;
        end else begin
            swb_cnt_q <= swb_cnt_q + 1'b1;
        end
    end

    // ---------------- mode FSM ----------------
    state_e        state_q, state_d;
    logic [23:0]   timer_q, timer_d;
    logic          interlock_q, interlock_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          mode_change_q, mode_change_d;
    logic          motors_stopped;

    assign motors_stopped = (curr_motor_rate <= MOT_MIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (interlock_q && swa_db_q && (throttle_rec_val <= THR_MAX)) begin
                    state_d = swb_db_q ? StTakeoff : StManual;
                end
            end
            StTakeoff: begin
                if (!swa_db_q)                   state_d = StLand;
                else if (!swb_db_q)              state_d = StManual;
                else if (timer_q == TAKEOFF_LAST) state_d = StHover;
            end
            StHover: begin
                if (!swa_db_q)      state_d = StLand;
                else if (!swb_db_q) state_d = StManual;
            end
            StManual: begin
                if (!swa_db_q)     state_d = motors_stopped ? StIdle : StLand;
                else if (swb_db_q) state_d = StHover;
            end
            StLand: begin
                // Pilot override back to manual wins over the landing exit.
                if (swa_db_q && !swb_db_q)                     state_d = StManual;
                else if (motors_stopped || timer_q == LAND_LAST) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        interlock_d = interlock_q;
        // Any entry into IDLE drops the interlock so arming needs a fresh off->on of swa.
        if (state_d == StIdle && state_q != StIdle) begin
            interlock_d = 1'b0;
        end else if (state_q == StIdle && !swa_db_q) begin
            interlock_d = 1'b1;
        end

        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 24'd1;
        end

        sel_d = REC_SEL_OFF;
        case (state_d)
            StTakeoff: sel_d = REC_SEL_AUTO_TAKE_OFF;
            StHover:   sel_d = REC_SEL_HOVER;
            StManual:  sel_d = REC_SEL_PASS_THROUGH;
            StLand:    sel_d = REC_SEL_AUTO_LAND;
            default:   sel_d = REC_SEL_OFF;
        endcase

        mode_change_d = (sel_d != sel_q);
    end

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            interlock_q   <= 1'b0;
            sel_q         <= REC_SEL_OFF;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            interlock_q   <= interlock_d;
            sel_q         <= sel_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign rec_data_sel = sel_q;
    assign mode_change  = mode_change_q;
    assign DEBUG_WIRE   = DW'({interlock_q, swb_db_q, swa_db_q, state_q});

endmodule

// File: tb/tb_flight_mode.sv
`ifndef PWM_VALUE_BIT_WIDTH
`define PWM_VALUE_BIT_WIDTH 8
`endif
`ifndef REC_DATA_SEL_BIT_WIDTH
`define REC_DATA_SEL_BIT_WIDTH 3
`endif
`ifndef DEBUG_WIRE_BIT_WIDTH
`define DEBUG_WIRE_BIT_WIDTH 8
`endif

module tb_flight_mode;

    localparam int DB = 4;
    localparam int TK = 10;
    localparam int LT = 20;

    logic us_clk = 1'b0;
    logic reset  = 1'b1;
    logic [`PWM_VALUE_BIT_WIDTH-1:0]    swa_val = 8'd250;
    logic [`PWM_VALUE_BIT_WIDTH-1:0]    swb_val = 8'd0;
    logic [`PWM_VALUE_BIT_WIDTH-1:0]    throttle_rec_val = 8'd0;
    logic [`PWM_VALUE_BIT_WIDTH-1:0]    curr_motor_rate = 8'd0;
    logic [`REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel;
    logic                               mode_change;
    logic [`DEBUG_WIRE_BIT_WIDTH-1:0]   DEBUG_WIRE;

    flight_mode #(
        .DEBOUNCE_US     (DB),
        .TAKEOFF_US      (TK),
        .LAND_TIMEOUT_US (LT)
    ) dut (
        .us_clk           (us_clk),
        .reset            (reset),
        .swa_val          (swa_val),
        .swb_val          (swb_val),
        .throttle_rec_val (throttle_rec_val),
        .curr_motor_rate  (curr_motor_rate),
        .rec_data_sel     (rec_data_sel),
        .mode_change      (mode_change),
        .DEBUG_WIRE       (DEBUG_WIRE)
    );

    always #5 us_clk = ~us_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model, expressed in selector codes:
    // 0 off, 1 auto takeoff, 2 hover, 3 pass-through, 4 auto land.
    int m_mode, m_t, m_run_a, m_run_b;
    bit m_db_a, m_db_b, m_ilk, m_chg;

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_run_a = 0; m_run_b = 0;
        m_db_a = 1'b1; m_db_b = 1'b0; m_ilk = 1'b0; m_chg = 1'b0;
    endtask

    // A debounced level follows the raw level after DB consecutive differing samples.
    task automatic deb(input bit raw, inout bit db, inout int run);
        if (raw != db) begin
            run++;
            if (run == DB) begin
                db  = raw;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_update();
        int  nxt;
        bit  stopped;
        stopped = (curr_motor_rate <= 10);
        nxt = m_mode;
        case (m_mode)
            0: if (m_ilk && m_db_a && throttle_rec_val <= 20) nxt = m_db_b ? 1 : 3;
            1: if (!m_db_a) nxt = 4; else if (!m_db_b) nxt = 3; else if (m_t == TK - 1) nxt = 2;
            2: if (!m_db_a) nxt = 4; else if (!m_db_b) nxt = 3;
            3: if (!m_db_a) nxt = stopped ? 0 : 4; else if (m_db_b) nxt = 2;
            4: if (m_db_a && !m_db_b) nxt = 3; else if (stopped || m_t == LT - 1) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 0 && m_mode != 0) m_ilk = 1'b0;
        else if (m_mode == 0 && !m_db_a) m_ilk = 1'b1;
        m_chg  = (nxt != m_mode);
        m_t    = m_chg ? 0 : m_t + 1;
        m_mode = nxt;
        deb(swa_val >= 128, m_db_a, m_run_a);
        deb(swb_val >= 128, m_db_b, m_run_b);
    endtask

    task automatic step();
        @(posedge us_clk);
        model_update();
        #1;
        check("sel", int'(rec_data_sel), m_mode);
        check("mode_change", int'(mode_change), int'(m_chg));
        check("debug_flags", int'(DEBUG_WIRE[5:3]), int'({m_ilk, m_db_b, m_db_a}));
    endtask

    typedef struct {
        int swa; int swb; int thr; int rate; int n; int exp;
    } vec_t;

    function automatic vec_t mk(int swa, int swb, int thr, int rate, int n, int exp);
        vec_t v;
        v.swa = swa; v.swb = swb; v.thr = thr; v.rate = rate; v.n = n; v.exp = exp;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Interlock: swa on at power-up must not arm; off then on arms into pass-through.
        vt.push_back(mk(250,   0,   0,  0, 100, 0));
        vt.push_back(mk(  0,   0,   0,  0,   4, 0));
        vt.push_back(mk(250,   0,   0,  0,   4, 0));
        vt.push_back(mk(250,   0,   0,  0,   1, 3));
        vt.push_back(mk(  0,   0,   0,  0,   4, 3));
        vt.push_back(mk(  0,   0,   0,  0,   1, 0));
        // Throttle interlock.
        vt.push_back(mk(  0,   0, 100,  0,   2, 0));
        vt.push_back(mk(250,   0, 100,  0,  15, 0));
        vt.push_back(mk(250,   0,   5,  0,   1, 3));
        vt.push_back(mk(  0,   0,   0,  0,   5, 0));
        // Auto takeoff -> hover -> manual -> hover.
        vt.push_back(mk(  0, 250,   0,  0,   4, 0));
        vt.push_back(mk(250, 250,   0,  0,   4, 0));
        vt.push_back(mk(250, 250,   0,  0,   1, 1));
        vt.push_back(mk(250, 250,   0,  0,   9, 1));
        vt.push_back(mk(250, 250,   0,  0,   1, 2));
        vt.push_back(mk(250,   0,   0,  0,   4, 2));
        vt.push_back(mk(250,   0,   0,  0,   1, 3));
        vt.push_back(mk(250, 250,   0,  0,   4, 3));
        vt.push_back(mk(250, 250,   0,  0,   1, 2));
        // Glitch rejection, then disarm into land and land timeout.
        vt.push_back(mk(  0, 250,   0, 50,   3, 2));
        vt.push_back(mk(250, 250,   0, 50,   3, 2));
        vt.push_back(mk(  0, 250,   0, 50,   4, 2));
        vt.push_back(mk(  0, 250,   0, 50,   1, 4));
        vt.push_back(mk(  0, 250,   0, 50,  19, 4));
        vt.push_back(mk(  0, 250,   0, 50,   1, 0));
        // Land ended by motors stopping.
        vt.push_back(mk(250, 250,   0, 50,   4, 0));
        vt.push_back(mk(250, 250,   0, 50,   1, 1));
        vt.push_back(mk(  0, 250,   0, 50,   4, 1));
        vt.push_back(mk(  0, 250,   0, 50,   1, 4));
        vt.push_back(mk(  0, 250,   0, 50,   5, 4));
        vt.push_back(mk(  0, 250,   0, 10,   1, 0));
        // Land ended by pilot override.
        vt.push_back(mk(250, 250,   0, 50,   4, 0));
        vt.push_back(mk(250, 250,   0, 50,   1, 1));
        vt.push_back(mk(  0, 250,   0, 50,   4, 1));
        vt.push_back(mk(  0, 250,   0, 50,   1, 4));
        vt.push_back(mk(250,   0,   0, 50,   4, 4));
        vt.push_back(mk(250,   0,   0, 50,   1, 3));
        // Disarm with motors stopped, then re-arm into takeoff.
        vt.push_back(mk(  0,   0,   0,  0,   4, 3));
        vt.push_back(mk(  0,   0,   0,  0,   1, 0));
        vt.push_back(mk(  0, 250,   0,  0,   2, 0));
        vt.push_back(mk(250, 250,   0,  0,   4, 0));
        vt.push_back(mk(250, 250,   0,  0,   1, 1));

        model_reset();
        repeat (3) @(posedge us_clk);
        #1;
        check("reset_sel", int'(rec_data_sel), 0);
        check("reset_mode_change", int'(mode_change), 0);
        check("reset_flags", int'(DEBUG_WIRE[5:3]), 1);
        reset = 1'b0;

        foreach (vt[i]) begin
            swa_val          = 8'(vt[i].swa);
            swb_val          = 8'(vt[i].swb);
            throttle_rec_val = 8'(vt[i].thr);
            curr_motor_rate  = 8'(vt[i].rate);
            repeat (vt[i].n) step();
            check($sformatf("vec%0d_sel", i), int'(rec_data_sel), vt[i].exp);
        end

        // Asynchronous reset right after entering takeoff, between clock edges.
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_sel", int'(rec_data_sel), 0);
        check("async_reset_mode_change", int'(mode_change), 0);
        check("async_reset_flags", int'(DEBUG_WIRE[5:3]), 1);
        model_reset();
        repeat (2) @(posedge us_clk);
        #1;
        reset = 1'b0;
        // swa held on after reset must not re-arm.
        repeat (20) step();
        check("no_rearm_after_reset", int'(rec_data_sel), 0);

        // Randomized phase: switches change occasionally, throttle mostly low.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) swa_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) swb_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) throttle_rec_val = 8'($urandom_range(0, 255));
            else throttle_rec_val = 8'($urandom_range(0, 25));
            curr_motor_rate = 8'($urandom_range(0, 60));
            repeat ($urandom_range(1, 8)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
